// File: rtl/probe_scheduler.sv
// Probe scheduler: fires transceiver START pulses every INTERVAL clocks for GROUPS probes,
// tracking the BUSY handshake, interval overruns, acknowledge timeouts and host abort.
module probe_scheduler #(
    parameter int unsigned ACK_TIMEOUT = 1000,
    parameter int unsigned MIN_GAP     = 4
) (
    input  logic        CLOCK_10M,
    input  logic        RESET_N,
    input  logic        ARM,
    input  logic        ABORT,
    input  logic        CONFIG_READY,
    input  logic [31:0] INTERVAL,
    input  logic [15:0] GROUPS,
    input  logic        TRANSC_BUSY,
    output logic        START,
    output logic        RUNNING,
    output logic        DONE,
    output logic        ABORTED,
    output logic [15:0] GROUP_CNT,
    output logic        OVERRUN,
    output logic        ACK_ERR
);

    localparam int unsigned IVL_W = 32;
    localparam int unsigned GRP_W = 16;
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_BUSY,
        S_WAIT_IVL,
        S_GAP,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               arm_q;
    logic [IVL_W-1:0]   shadow_ivl_q;
    logic [GRP_W-1:0]   shadow_grp_q;
    logic [IVL_W-1:0]   ivl_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic               start_d;
    logic               running_d;
    logic               done_d;
    logic               aborted_d;
    logic               overrun_d;
    logic               ack_err_d;
    logic [GRP_W-1:0]   group_cnt_d;

    logic               arm_edge_c;
    logic               arm_ok_c;
    logic               accept_c;
    logic               empty_run_c;
    logic               ivl_due_c;
    logic               ack_timeout_c;
    logic               gap_done_c;
    logic [GRP_W-1:0]   cnt_inc_c;
    logic               last_c;

    assign arm_edge_c    = ARM & ~arm_q;
    assign arm_ok_c      = (state_q == S_IDLE) && arm_edge_c && !ABORT && CONFIG_READY;
    assign accept_c      = arm_ok_c && (GROUPS != '0);
    assign empty_run_c   = arm_ok_c && (GROUPS == '0);
    assign ivl_due_c     = ivl_cnt_q >= (shadow_ivl_q - IVL_W'(1));
    assign ack_timeout_c = ivl_cnt_q >= IVL_W'(ACK_TIMEOUT - 1);
    assign gap_done_c    = gap_cnt_q >= GAP_W'(MIN_GAP);
    assign cnt_inc_c     = GROUP_CNT + GRP_W'(1);
    assign last_c        = cnt_inc_c == shadow_grp_q;

    // State register
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ABORT takes priority over probe progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) state_d = S_FIRE;
            end
            S_FIRE: begin
                if (ABORT)              state_d = TRANSC_BUSY ? S_DRAIN : S_FINISH;
                else if (TRANSC_BUSY)   state_d = S_WAIT_BUSY;
                else if (ack_timeout_c) state_d = S_FINISH;
            end
            S_WAIT_BUSY: begin
                if (!TRANSC_BUSY) begin
                    if (ABORT || last_c) state_d = S_FINISH;
                    else if (ivl_due_c)  state_d = S_GAP;
                    else                 state_d = S_WAIT_IVL;
                end else if (ABORT) begin
                    state_d = S_DRAIN;
                end
            end
            S_WAIT_IVL: begin
                if (ABORT)                         state_d = S_FINISH;
                else if (ivl_due_c && gap_done_c)  state_d = S_FIRE;
            end
            S_GAP: begin
                if (ABORT)           state_d = S_FINISH;
                else if (gap_done_c) state_d = S_FIRE;
            end
            S_DRAIN: begin
                if (!TRANSC_BUSY) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        start_d     = (state_d == S_FIRE);
        running_d   = state_d inside {S_FIRE, S_WAIT_BUSY, S_WAIT_IVL, S_GAP, S_DRAIN};
        done_d      = (state_d == S_FINISH) || empty_run_c;
        aborted_d   = ABORTED;
        overrun_d   = OVERRUN;
        ack_err_d   = ACK_ERR;
        group_cnt_d = GROUP_CNT;
        if (accept_c || empty_run_c) begin
            group_cnt_d = '0;
            aborted_d   = 1'b0;
        end
        if (accept_c) begin
            overrun_d = 1'b0;
            ack_err_d = 1'b0;
        end
        case (state_q)
            S_FIRE: begin
                if (ABORT) begin
                    aborted_d = 1'b1;
                end else if (!TRANSC_BUSY && ack_timeout_c) begin
                    aborted_d = 1'b1;
                    ack_err_d = 1'b1;
                end
            end
            S_WAIT_BUSY: begin
                if (ABORT)                aborted_d   = 1'b1;
                if (!TRANSC_BUSY)         group_cnt_d = cnt_inc_c;
                if (state_d == S_GAP)     overrun_d   = 1'b1;
            end
            S_WAIT_IVL, S_GAP: begin
                if (ABORT) aborted_d = 1'b1;
            end
            S_DRAIN: begin
                if (!TRANSC_BUSY) group_cnt_d = cnt_inc_c;
            end
            default: ;
        endcase
    end

    // Output registers, shadow copies and interval/gap counters
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            arm_q        <= 1'b0;
            START        <= 1'b0;
            RUNNING      <= 1'b0;
            DONE         <= 1'b0;
            ABORTED      <= 1'b0;
            OVERRUN      <= 1'b0;
            ACK_ERR      <= 1'b0;
            GROUP_CNT    <= '0;
            shadow_ivl_q <= '0;
            shadow_grp_q <= '0;
            ivl_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            arm_q     <= ARM;
            START     <= start_d;
            RUNNING   <= running_d;
            DONE      <= done_d;
            ABORTED   <= aborted_d;
            OVERRUN   <= overrun_d;
            ACK_ERR   <= ack_err_d;
            GROUP_CNT <= group_cnt_d;
            if (accept_c) begin
                shadow_ivl_q <= (INTERVAL == '0) ? IVL_W'(1) : INTERVAL;
                shadow_grp_q <= GROUPS;
            end
            if (start_d && !START) begin
                ivl_cnt_q <= '0;
            end else if (RUNNING && (ivl_cnt_q != '1)) begin
                ivl_cnt_q <= ivl_cnt_q + IVL_W'(1);
            end
            // gap_cnt includes the current low cycle, so it reads 1 in the first cycle after START falls
            if (state_q == S_FIRE) begin
                gap_cnt_q <= (state_d == S_FIRE) ? '0 : GAP_W'(1);
            end else if (!gap_done_c) begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_probe_scheduler.sv
// Randomized bench for probe_scheduler against an event-level schedule model
// (probe start/fall/complete times derived from interval, gap floor and BUSY timing).
module tb_probe_scheduler;

    localparam int ACK_TIMEOUT = 1000;
    localparam int MIN_GAP     = 4;

    logic        CLOCK_10M;
    logic        RESET_N;
    logic        ARM;
    logic        ABORT;
    logic        CONFIG_READY;
    logic [31:0] INTERVAL;
    logic [15:0] GROUPS;
    logic        TRANSC_BUSY;
    logic        START;
    logic        RUNNING;
    logic        DONE;
    logic        ABORTED;
    logic [15:0] GROUP_CNT;
    logic        OVERRUN;
    logic        ACK_ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int d_arr [16];
    int l_arr [16];

    probe_scheduler dut (
        .CLOCK_10M    (CLOCK_10M),
        .RESET_N      (RESET_N),
        .ARM          (ARM),
        .ABORT        (ABORT),
        .CONFIG_READY (CONFIG_READY),
        .INTERVAL     (INTERVAL),
        .GROUPS       (GROUPS),
        .TRANSC_BUSY  (TRANSC_BUSY),
        .START        (START),
        .RUNNING      (RUNNING),
        .DONE         (DONE),
        .ABORTED      (ABORTED),
        .GROUP_CNT    (GROUP_CNT),
        .OVERRUN      (OVERRUN),
        .ACK_ERR      (ACK_ERR)
    );

    initial CLOCK_10M = 1'b0;
    always #50 CLOCK_10M = ~CLOCK_10M;

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_10M);
        #1;
        cyc++;
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One run: model the expected schedule, then drive ARM/BUSY/ABORT and compare events
    task automatic run_case(input string name, input int ivl, input int grp, input int ab_rel);
        int c, t0, ab, s, f, cc, sn, ivl_e, run_len, probe, bon, boff;
        int exp_s[$], exp_f[$], obs_s[$], obs_f[$];
        int exp_done, exp_cnt, done_obs, done_pulses, cnt_obs;
        bit exp_ab, exp_ov, exp_ae, to;
        logic ab_obs, ov_obs, ae_obs, run_t0, run_done, start_prev;

        c        = cyc;
        t0       = c + 1;
        ab       = (ab_rel < 0) ? -1 : t0 + ab_rel;
        ivl_e    = (ivl < 1) ? 1 : ivl;
        s        = t0;
        exp_done = 0;
        exp_cnt  = 0;
        exp_ab   = 0;
        exp_ov   = 0;
        exp_ae   = 0;
        for (int n = 0; n < grp; n++) begin
            to = d_arr[n] >= ACK_TIMEOUT;
            exp_s.push_back(s);
            f  = to ? s + ACK_TIMEOUT : s + d_arr[n] + 1;
            cc = s + d_arr[n] + l_arr[n] + 1;
            if (ab >= s && ab < f) begin
                exp_f.push_back(ab + 1);
                exp_ab = 1;
                if (!to && ab == s + d_arr[n]) begin
                    exp_done = cc;
                    exp_cnt  = n + 1;
                end else begin
                    exp_done = ab + 1;
                    exp_cnt  = n;
                end
                break;
            end
            exp_f.push_back(f);
            if (to) begin
                exp_done = f;
                exp_cnt  = n;
                exp_ae   = 1;
                exp_ab   = 1;
                break;
            end
            if ((ab >= f && ab < cc) || n == grp - 1) begin
                exp_done = cc;
                exp_cnt  = n + 1;
                exp_ab   = (ab >= f && ab < cc);
                break;
            end
            if (d_arr[n] + l_arr[n] >= ivl_e - 1) exp_ov = 1;
            sn = max3(s + ivl_e, f + MIN_GAP, cc + 1);
            if (ab >= cc && ab < sn) begin
                exp_done = ab + 1;
                exp_cnt  = n + 1;
                exp_ab   = 1;
                break;
            end
            s = sn;
        end

        INTERVAL     = 32'(ivl);
        GROUPS       = 16'(grp);
        CONFIG_READY = 1'b1;
        ABORT        = 1'b0;
        ARM          = 1'b1;
        run_len      = exp_done - c + 6;
        start_prev   = 1'b0;
        probe        = -1;
        bon          = -1;
        boff         = -1;
        done_obs     = -1;
        done_pulses  = 0;
        cnt_obs      = -1;
        ab_obs       = 1'bx;
        ov_obs       = 1'bx;
        ae_obs       = 1'bx;
        run_t0       = 1'b0;
        run_done     = 1'bx;
        for (int k = 0; k < run_len; k++) begin
            step();
            if (cyc == c + 3) ARM = 1'b0;
            if (exp_done > c + 20 && cyc == c + 12) ARM = 1'b1;
            if (cyc == c + 14) ARM = 1'b0;
            if (cyc == t0) begin
                run_t0   = RUNNING;
                INTERVAL = $urandom;
                GROUPS   = 16'($urandom);
            end
            if (START && !start_prev) begin
                obs_s.push_back(cyc);
                probe++;
                if (probe < 16 && d_arr[probe] < ACK_TIMEOUT) begin
                    bon  = cyc + d_arr[probe];
                    boff = bon + l_arr[probe];
                end else begin
                    bon  = -1;
                    boff = -1;
                end
            end
            if (!START && start_prev) obs_f.push_back(cyc);
            start_prev = START;
            if (DONE) begin
                done_pulses++;
                if (done_obs < 0) begin
                    done_obs = cyc;
                    cnt_obs  = 32'(GROUP_CNT);
                    ab_obs   = ABORTED;
                    ov_obs   = OVERRUN;
                    ae_obs   = ACK_ERR;
                    run_done = RUNNING;
                end
            end
            TRANSC_BUSY = (cyc >= bon && cyc < boff);
            ABORT       = (cyc == ab);
        end
        TRANSC_BUSY = 1'b0;
        ABORT       = 1'b0;

        check_val({name, ".running_t0"}, 32'(run_t0), 32'd1);
        check_val({name, ".n_start"}, obs_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size(); i++) begin
            if (i < obs_s.size()) check_val($sformatf("%s.start%0d", name, i), obs_s[i] - t0, exp_s[i] - t0);
            if (i < exp_f.size() && i < obs_f.size())
                check_val($sformatf("%s.fall%0d", name, i), obs_f[i] - t0, exp_f[i] - t0);
        end
        check_val({name, ".done_cycle"}, done_obs - t0, exp_done - t0);
        check_val({name, ".done_pulses"}, done_pulses, 1);
        check_val({name, ".group_cnt"}, cnt_obs, exp_cnt);
        check_val({name, ".aborted"}, 32'(ab_obs), 32'(exp_ab));
        check_val({name, ".overrun"}, 32'(ov_obs), 32'(exp_ov));
        check_val({name, ".ack_err"}, 32'(ae_obs), 32'(exp_ae));
        check_val({name, ".running_done"}, 32'(run_done), 32'd0);
        check_val({name, ".cnt_hold"}, 32'(GROUP_CNT), exp_cnt);
    endtask

    task automatic fill_probes(input int d, input int l);
        for (int i = 0; i < 16; i++) begin
            d_arr[i] = d;
            l_arr[i] = l;
        end
    endtask

    int c0;
    int act;

    initial begin
        RESET_N      = 1'b0;
        ARM          = 1'b0;
        ABORT        = 1'b0;
        CONFIG_READY = 1'b0;
        INTERVAL     = '0;
        GROUPS       = '0;
        TRANSC_BUSY  = 1'b0;
        repeat (3) step();
        check_val("reset_outputs", 32'({START, RUNNING, DONE, ABORTED, OVERRUN, ACK_ERR, GROUP_CNT}), 32'd0);
        #10 RESET_N = 1'b1;
        repeat (2) step();

        fill_probes(2, 20);
        run_case("basic", 100, 3, -1);
        fill_probes(2, 30);
        run_case("overrun", 10, 2, -1);
        fill_probes(ACK_TIMEOUT + 500, 1);
        run_case("ack_timeout", 50, 3, -1);
        fill_probes(2, 20);
        run_case("abort_busy", 60, 5, 70);

        // GROUPS=0: immediate DONE, no probe, status cleared
        GROUPS       = '0;
        CONFIG_READY = 1'b1;
        ARM          = 1'b1;
        step();
        check_val("empty.done", 32'(DONE), 32'd1);
        check_val("empty.start", 32'(START), 32'd0);
        check_val("empty.group_cnt", 32'(GROUP_CNT), 32'd0);
        check_val("empty.aborted", 32'(ABORTED), 32'd0);
        ARM = 1'b0;
        step();
        check_val("empty.done_end", 32'(DONE), 32'd0);
        repeat (3) step();

        // ARM edge ignored without CONFIG_READY, or with ABORT held
        for (int v = 0; v < 2; v++) begin
            act          = 0;
            CONFIG_READY = (v == 1);
            ABORT        = (v == 1);
            GROUPS       = 16'd3;
            INTERVAL     = 32'd20;
            ARM          = 1'b1;
            for (int k = 0; k < 20; k++) begin
                step();
                if (k == 2) ARM = 1'b0;
                if (START || RUNNING || DONE) act++;
            end
            check_val($sformatf("ignored_arm%0d", v), act, 0);
        end
        ABORT        = 1'b0;
        CONFIG_READY = 1'b1;

        // Asynchronous reset while waiting for the next interval
        INTERVAL = 32'd100;
        GROUPS   = 16'd3;
        ARM      = 1'b1;
        c0       = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            if (cyc == c0 + 3) ARM = 1'b0;
            TRANSC_BUSY = (cyc >= c0 + 3 && cyc < c0 + 23);
        end
        check_val("prerst.group_cnt", 32'(GROUP_CNT), 32'd1);
        check_val("prerst.running", 32'(RUNNING), 32'd1);
        #20 RESET_N = 1'b0;
        #1;
        check_val("midrun_reset", 32'({START, RUNNING, DONE, ABORTED, OVERRUN, ACK_ERR, GROUP_CNT}), 32'd0);
        #10 RESET_N = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (START || RUNNING || DONE) act++;
        end
        check_val("postrst_idle", act, 0);
        fill_probes(1, 5);
        run_case("after_reset", 30, 2, -1);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 16; i++) begin
                d_arr[i] = $urandom_range(0, 4);
                l_arr[i] = $urandom_range(1, 25);
            end
            run_case($sformatf("rand%0d", r),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40),
                     $urandom_range(1, 5),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) : -1);
            repeat (2) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
